pipelined_control_unit: RTL and testbench

Parametrised, registered successor to the combinational decode controller of the 16-bit RISC pipeline. Decodes the opcode of the instruction in the decode stage, sequences the two-word LDM (opcode word, then immediate word), detects load-use hazards against the instruction already in execute, and drives the ID/EX control register with stall and flush support. It sits between the IF/ID register and the execute stage.

---
 rtl/cu_pkg.sv | 54 +++++
 rtl/pipelined_control_unit_if.sv | 40 ++++
 rtl/cu_decode.sv | 40 ++++
 rtl/pipelined_control_unit.sv | 124 ++++++++++++
 tb/tb_pipelined_control_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the pipelined decode controller.
// Opcode map, ALU op codes, ID/EX control word and FSM states.
package cu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDM  = 3'b001;
  localparam logic [2:0] OP_STD  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_NOP2 = 3'b101;
  localparam logic [2:0] OP_LDD  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NOT  = 2'b01;
  localparam logic [1:0] ALU_STD  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  typedef struct packed {
    logic       alu_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       imm_sel;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{
    alu_to_reg: 1'b0, reg_write: 1'b0,
    mem_read: 1'b0, mem_write: 1'b0,
    alu_op: ALU_PASS, imm_sel: 1'b0
  };

  localparam ctrl_t LDM_CW = '{
    alu_to_reg: 1'b1, reg_write: 1'b1,
    mem_read: 1'b0, mem_write: 1'b0,
    alu_op: ALU_PASS, imm_sel: 1'b1
  };

  typedef enum logic {
    S_DECODE,
    S_IMM
  } state_t;

  // Opcodes whose source registers are read in execute.
  function automatic logic reads_regs(
    input logic [2:0] op
  );
    return (op == OP_STD) ||
           (op == OP_ADD) ||
           (op == OP_NOT);
  endfunction

endpackage

// File: rtl/pipelined_control_unit_if.sv
// IF/ID-to-ID/EX control bundle between the fetch side
// and the decode controller.
interface pipelined_control_unit_if #(
  parameter int INST_W = 16,
  parameter int REG_W  = 3
);
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              flush;
  logic              hold_ext;
  logic              stall;
  logic              illegal;
  logic              ex_alu_to_reg;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [1:0]        ex_alu_op;
  logic              ex_imm_sel;
  logic [INST_W-1:0] ex_imm;
  logic [REG_W-1:0]  ex_rdst;
  logic [REG_W-1:0]  ex_rsrc;

  modport master (
    output inst, inst_valid, flush, hold_ext,
    input  stall, illegal,
    input  ex_alu_to_reg, ex_reg_write,
    input  ex_mem_read, ex_mem_write,
    input  ex_alu_op, ex_imm_sel, ex_imm,
    input  ex_rdst, ex_rsrc
  );

  modport slave (
    input  inst, inst_valid, flush, hold_ext,
    output stall, illegal,
    output ex_alu_to_reg, ex_reg_write,
    output ex_mem_read, ex_mem_write,
    output ex_alu_op, ex_imm_sel, ex_imm,
    output ex_rdst, ex_rsrc
  );
endinterface

// File: rtl/cu_decode.sv
// Combinational opcode to control-word map.
// LDM's word here is the one loaded with its immediate.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               cw
);

  // One-hot select of the control word for each opcode.
  always_comb begin
    cw = BUBBLE;
    unique case (1'b1)
      (opcode == OP_LDM): cw = LDM_CW;
      (opcode == OP_STD): begin
        cw.mem_write = 1'b1;
        cw.alu_op    = ALU_STD;
      end
      (opcode == OP_ADD): begin
        cw.alu_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
        cw.alu_op     = ALU_ADD;
      end
      (opcode == OP_NOT): begin
        cw.alu_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
        cw.alu_op     = ALU_NOT;
      end
      (opcode == OP_LDD): begin
        cw.mem_read  = 1'b1;
        cw.reg_write = 1'b1;
        cw.alu_op    = ALU_STD;
      end
      default: cw = BUBBLE;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered decode controller: LDM sequencing, load-use
// stall, flush/hold priority and the ID/EX control register.
module pipelined_control_unit
  import cu_pkg::*;
#(
  parameter int INST_W   = 16,
  parameter int OPCODE_W = 3,
  parameter int REG_W    = 3
) (
  input logic clk,
  input logic rst,
  pipelined_control_unit_if.slave bus
);

  localparam int RD_HI = INST_W - OPCODE_W - 1;
  localparam int RS_HI = RD_HI - REG_W;

  logic [OPCODE_W-1:0] op;
  logic [REG_W-1:0]    rdst;
  logic [REG_W-1:0]    rsrc;
  ctrl_t               dec_cw;

  assign op   = bus.inst[INST_W-1 -: OPCODE_W];
  assign rdst = bus.inst[RD_HI -: REG_W];
  assign rsrc = bus.inst[RS_HI -: REG_W];

  cu_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode (op),
    .cw     (dec_cw)
  );

  state_t            state, nxt_state;
  ctrl_t             cw_q, nxt_cw;
  logic [INST_W-1:0] imm_q, nxt_imm;
  logic [REG_W-1:0]  rdst_q, nxt_rdst;
  logic [REG_W-1:0]  rsrc_q, nxt_rsrc;
  logic [REG_W-1:0]  ldm_rd, nxt_ldm;
  logic              ill_q, nxt_ill;
  logic              hazard;
  logic              uses_regs;

  assign uses_regs = reads_regs(op) ||
                     (op == OP_LDD);

  // Immediate words (S_IMM) are data, never hazard-checked.
  assign hazard = (state == S_DECODE) &&
                  bus.inst_valid &&
                  cw_q.mem_read &&
                  reads_regs(op) &&
                  ((rdst == rdst_q) ||
                   (rsrc == rdst_q));

  assign bus.stall = rst && !bus.flush &&
                     (bus.hold_ext || hazard);

  // Next ID/EX contents; default is a bubble.
  always_comb begin
    nxt_state = state;
    nxt_ldm   = ldm_rd;
    nxt_cw    = BUBBLE;
    nxt_imm   = '0;
    nxt_rdst  = '0;
    nxt_rsrc  = '0;
    nxt_ill   = 1'b0;
    if (bus.flush) begin
      nxt_state = S_DECODE;
      nxt_ldm   = '0;
    end else if (hazard) begin
      nxt_state = state;
    end else if (state == S_IMM) begin
      if (bus.inst_valid) begin
        nxt_cw    = LDM_CW;
        nxt_imm   = bus.inst;
        nxt_rdst  = ldm_rd;
        nxt_state = S_DECODE;
      end
    end else if (bus.inst_valid) begin
      if (op == OP_LDM) begin
        nxt_ldm   = rdst;
        nxt_state = S_IMM;
      end else begin
        nxt_cw  = dec_cw;
        nxt_ill = (op == OP_RSV);
        if (uses_regs) begin
          nxt_rdst = rdst;
          nxt_rsrc = rsrc;
        end
      end
    end
  end

  // ID/EX register and FSM; hold freezes all unless flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_DECODE;
      ldm_rd <= '0;
      cw_q   <= BUBBLE;
      imm_q  <= '0;
      rdst_q <= '0;
      rsrc_q <= '0;
      ill_q  <= 1'b0;
    end else if (bus.flush || !bus.hold_ext) begin
      state  <= nxt_state;
      ldm_rd <= nxt_ldm;
      cw_q   <= nxt_cw;
      imm_q  <= nxt_imm;
      rdst_q <= nxt_rdst;
      rsrc_q <= nxt_rsrc;
      ill_q  <= nxt_ill;
    end
  end

  assign bus.illegal       = ill_q;
  assign bus.ex_alu_to_reg = cw_q.alu_to_reg;
  assign bus.ex_reg_write  = cw_q.reg_write;
  assign bus.ex_mem_read   = cw_q.mem_read;
  assign bus.ex_mem_write  = cw_q.mem_write;
  assign bus.ex_alu_op     = cw_q.alu_op;
  assign bus.ex_imm_sel    = cw_q.imm_sel;
  assign bus.ex_imm        = imm_q;
  assign bus.ex_rdst       = rdst_q;
  assign bus.ex_rsrc       = rsrc_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: reset, decode,
// LDM, load-use, flush, hold, illegal and reset mid-LDM.
module tb_pipelined_control_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pipelined_control_unit_if #(.INST_W(16), .REG_W(3)) bus ();

  pipelined_control_unit #(
    .INST_W(16), .OPCODE_W(3), .REG_W(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
      $error("check %s wrong", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cw(
    input string tag,
    input logic  a2r,
    input logic  rw,
    input logic  mr,
    input logic  mw,
    input logic [1:0] aop,
    input logic  isel
  );
    chk({tag, ".a2r"}, 32'(bus.ex_alu_to_reg), 32'(a2r));
    chk({tag, ".rw"},  32'(bus.ex_reg_write),  32'(rw));
    chk({tag, ".mr"},  32'(bus.ex_mem_read),   32'(mr));
    chk({tag, ".mw"},  32'(bus.ex_mem_write),  32'(mw));
    chk({tag, ".aop"}, 32'(bus.ex_alu_op),     32'(aop));
    chk({tag, ".isel"}, 32'(bus.ex_imm_sel),   32'(isel));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.inst       = 16'($urandom);
    bus.inst_valid = 1'b1;
    bus.flush      = 1'b0;
    bus.hold_ext   = 1'b1;

    // reset with random word and hold asserted
    step();
    bus.inst = 16'($urandom);
    step();
    chk_cw("rst", 0, 0, 0, 0, 2'b11, 0);
    chk("rst.stall", 32'(bus.stall), 0);
    chk("rst.ill", 32'(bus.illegal), 0);
    chk("rst.imm", 32'(bus.ex_imm), 0);
    chk("rst.rdst", 32'(bus.ex_rdst), 0);

    // ADD R1,R2
    rst = 1'b1;
    bus.hold_ext = 1'b0;
    bus.inst = 16'h6500;
    step();
    chk_cw("add", 1, 1, 0, 0, 2'b00, 0);
    chk("add.rdst", 32'(bus.ex_rdst), 1);
    chk("add.rsrc", 32'(bus.ex_rsrc), 2);

    // LDM R1, 0x00AB then NOT R1,R2
    bus.inst = 16'h2400;
    step();
    chk_cw("ldm1", 0, 0, 0, 0, 2'b11, 0);
    bus.inst = 16'h00AB;
    step();
    chk_cw("ldm2", 1, 1, 0, 0, 2'b11, 1);
    chk("ldm2.imm", 32'(bus.ex_imm), 32'h00AB);
    chk("ldm2.rdst", 32'(bus.ex_rdst), 1);
    bus.inst = 16'h8500;
    step();
    chk_cw("not", 1, 1, 0, 0, 2'b01, 0);
    chk("not.imm", 32'(bus.ex_imm), 0);

    // load-use: LDD R3 then ADD R1,R3
    bus.inst = 16'hCC00;
    step();
    chk_cw("ldd", 0, 1, 1, 0, 2'b10, 0);
    chk("ldd.rdst", 32'(bus.ex_rdst), 3);
    bus.inst = 16'h6580;
    #1;
    chk("lu.stall", 32'(bus.stall), 1);
    step();
    chk_cw("lu.bub", 0, 0, 0, 0, 2'b11, 0);
    chk("lu.stall0", 32'(bus.stall), 0);
    step();
    chk_cw("lu.add", 1, 1, 0, 0, 2'b00, 0);
    chk("lu.rsrc", 32'(bus.ex_rsrc), 3);

    // flush during S_IMM
    bus.inst = 16'h2400;
    step();
    bus.inst = 16'h00AB;
    bus.flush = 1'b1;
    #1;
    chk("fl.stall", 32'(bus.stall), 0);
    step();
    chk_cw("fl.bub", 0, 0, 0, 0, 2'b11, 0);
    bus.flush = 1'b0;
    step();
    chk_cw("fl.nop", 0, 0, 0, 0, 2'b11, 0);
    chk("fl.imm", 32'(bus.ex_imm), 0);

    // flush together with a load-use hazard
    bus.inst = 16'hCC00;
    step();
    bus.inst = 16'h6580;
    bus.flush = 1'b1;
    #1;
    chk("flhz.stall", 32'(bus.stall), 0);
    step();
    chk("flhz.mr", 32'(bus.ex_mem_read), 0);
    bus.flush = 1'b0;

    // hold_ext with STD R2,R1 in ID/EX
    bus.inst = 16'h4880;
    step();
    chk_cw("std", 0, 0, 0, 1, 2'b10, 0);
    bus.inst = 16'h6500;
    bus.hold_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold.stall", 32'(bus.stall), 1);
      step();
      chk("hold.mw", 32'(bus.ex_mem_write), 1);
    end
    bus.hold_ext = 1'b0;
    step();
    chk_cw("hold.add", 1, 1, 0, 0, 2'b00, 0);

    // reserved opcode
    bus.inst = 16'hE000;
    step();
    chk("ill.set", 32'(bus.illegal), 1);
    chk_cw("ill", 0, 0, 0, 0, 2'b11, 0);
    bus.inst = 16'h0000;
    step();
    chk("ill.clr", 32'(bus.illegal), 0);

    // reset in S_IMM: next word is an instruction
    bus.inst = 16'h2400;
    step();
    rst = 1'b0;
    #1;
    chk("rmid.stall", 32'(bus.stall), 0);
    bus.inst = 16'h6500;
    rst = 1'b1;
    step();
    chk_cw("rmid.add", 1, 1, 0, 0, 2'b00, 0);
    chk("rmid.rsrc", 32'(bus.ex_rsrc), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
